// File: rtl/simon_host_link_if.sv
// Byte-stream link between the host byte adapter (master) and simon_host_link (slave).
// A byte moves on a rising clk edge only when its valid and ready are both high;
// valid and its byte hold steady until taken, and ready does not depend on valid.
interface simon_host_link_if;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_ready;

  modport master (output in_valid, in_byte, out_ready,
                  input  in_ready, out_valid, out_byte);
  modport slave  (input  in_valid, in_byte, out_ready,
                  output in_ready, out_valid, out_byte);
endinterface

// File: rtl/simon_host_link.sv
// Host front end for the SIMON 96/144 core: collects command and operand bytes,
// runs the core key/data handshakes and streams the 12-byte result back out.
module simon_host_link #(
  parameter int N  = 48,
  parameter int M  = 3,
  parameter int KB = 18,
  parameter int DB = 12
) (
  input  logic                 clk,
  input  logic                 R,
  simon_host_link_if.slave     host,
  output logic                 newKey,
  output logic                 newData,
  output logic                 enc_dec,
  output logic                 readData,
  output logic [2*N-1:0]       plain,
  output logic [M-1:0][N-1:0]  key,
  input  logic                 ldKey,
  input  logic                 ldData,
  input  logic                 doneKey,
  input  logic                 doneData,
  input  logic [2*N-1:0]       cipher,
  output logic                 key_ok,
  output logic                 busy,
  output logic                 err,
  output logic [2:0]           fsm_state
);

  localparam int CW = $clog2((KB > DB) ? KB : DB);
  localparam logic [CW-1:0] KEY_LAST  = CW'(KB - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DB - 1);

  typedef enum logic [2:0] {
    IDLE, RX_KEY, LOAD_KEY, WAIT_KEY, RX_DATA, LOAD_DATA, WAIT_DATA, TX
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [M*N-1:0]    key_sr;
  logic [2*N-1:0]    tx_sr;
  logic              in_rdy;
  logic              out_vld;
  logic              take_in;
  logic              take_out;

  assign take_in       = host.in_valid && in_rdy;
  assign take_out      = out_vld && host.out_ready;
  assign host.in_ready  = in_rdy;
  assign host.out_valid = out_vld;
  assign host.out_byte  = tx_sr[2*N-1 -: 8];
  assign key           = key_sr;
  assign fsm_state     = state;

  always_ff @(posedge clk) begin
    if (R) begin
      state    <= IDLE;
      cnt      <= '0;
      key_sr   <= '0;
      plain    <= '0;
      tx_sr    <= '0;
      in_rdy   <= 1'b0;
      out_vld  <= 1'b0;
      newKey   <= 1'b0;
      newData  <= 1'b0;
      enc_dec  <= 1'b0;
      readData <= 1'b0;
      key_ok   <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      err      <= 1'b0;
      readData <= 1'b0;
      case (state)
        IDLE: begin
          in_rdy <= 1'b1;
          busy   <= 1'b0;
          if (take_in) begin
            cnt <= '0;
            case (host.in_byte)
              8'h4B: begin
                key_ok <= 1'b0;
                busy   <= 1'b1;
                state  <= RX_KEY;
              end
              8'h45: begin
                enc_dec <= 1'b1;
                busy    <= 1'b1;
                state   <= RX_DATA;
              end
              8'h44: begin
                enc_dec <= 1'b0;
                busy    <= 1'b1;
                state   <= RX_DATA;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        RX_KEY: begin
          if (take_in) begin
            key_sr <= {key_sr[M*N-9:0], host.in_byte};
            cnt    <= cnt + 1'b1;
            if (cnt == KEY_LAST) begin
              in_rdy <= 1'b0;
              newKey <= 1'b1;
              state  <= LOAD_KEY;
            end
          end
        end
        // ldKey with doneKey in the same cycle skips WAIT_KEY entirely.
        LOAD_KEY: begin
          if (ldKey) begin
            newKey <= 1'b0;
            if (doneKey) begin
              key_ok <= 1'b1;
              busy   <= 1'b0;
              in_rdy <= 1'b1;
              state  <= IDLE;
            end else begin
              state  <= WAIT_KEY;
            end
          end
        end
        WAIT_KEY: begin
          if (doneKey) begin
            key_ok <= 1'b1;
            busy   <= 1'b0;
            in_rdy <= 1'b1;
            state  <= IDLE;
          end
        end
        RX_DATA: begin
          if (take_in) begin
            plain <= {plain[2*N-9:0], host.in_byte};
            cnt   <= cnt + 1'b1;
            if (cnt == DATA_LAST) begin
              if (key_ok) begin
                in_rdy  <= 1'b0;
                newData <= 1'b1;
                state   <= LOAD_DATA;
              end else begin
                err   <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end
        end
        LOAD_DATA: begin
          if (ldData) begin
            newData <= 1'b0;
            if (doneData) begin
              tx_sr    <= cipher;
              readData <= 1'b1;
              out_vld  <= 1'b1;
              cnt      <= '0;
              state    <= TX;
            end else begin
              state    <= WAIT_DATA;
            end
          end
        end
        WAIT_DATA: begin
          if (doneData) begin
            tx_sr    <= cipher;
            readData <= 1'b1;
            out_vld  <= 1'b1;
            cnt      <= '0;
            state    <= TX;
          end
        end
        TX: begin
          if (take_out) begin
            tx_sr <= {tx_sr[2*N-9:0], 8'h00};
            cnt   <= cnt + 1'b1;
            if (cnt == DATA_LAST) begin
              out_vld <= 1'b0;
              busy    <= 1'b0;
              in_rdy  <= 1'b1;
              state   <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/simon_host_link.md
Name: simon_host_link

Overview:
Byte-serial host front end for the SIMON 96/144 cipher core. It receives command and operand bytes over a valid/ready stream and assembles the 144-bit key or the 96-bit block. It then drives the core's newKey/ldKey/doneKey and newData/ldData/doneData/readData handshakes, and returns the 12-byte result on an output valid/ready stream. It sits between a UART/bus byte adapter and the cipher core top.

Parameters:
N, 48, cipher word width in bits (block = 2N)
M, 3, number of key words (key = M*N bits)
KB, 18, key length in bytes (M*N/8)
DB, 12, block length in bytes (2N/8)

Ports:
clk  input  1  system clock
R  input  1  synchronous active-high reset
in_valid  input  1  in_byte is valid
in_byte  input  8  host byte
in_ready  output  1  block accepts in_byte this cycle
out_valid  output  1  out_byte is valid
out_byte  output  8  result byte
out_ready  input  1  sink accepts out_byte
newKey  output  1  key request to core
newData  output  1  data request to core
enc_dec  output  1  1 = encrypt, 0 = decrypt
readData  output  1  result acknowledge to core
plain  output  2N  block to core
key  output  M x N  key words to core
ldKey  input  1  core captured key
ldData  input  1  core captured block
doneKey  input  1  key expansion complete
doneData  input  1  cipher output valid
cipher  input  2N  core result
key_ok  output  1  an expanded key is resident in the core
busy  output  1  state is not IDLE
err  output  1  one-cycle error pulse

Behaviour:
- Reset (R=1 at a clock edge) sets state to IDLE. All outputs go to 0, including key_ok, plain, key and the byte counter, regardless of the current state. Reset mid-transaction abandons the transaction with no drain of the core. After reset the core is expected to be reset alongside this block.
- Byte transfer: an input byte is taken only when in_valid && in_ready. An output byte is taken only when out_valid && out_ready. Operand bytes are MSB first: the first key byte goes to key[M-1][N-1:N-8], and the first block byte goes to plain[2N-1:2N-8].
- States and transitions:
  - IDLE: in_ready=1. On command 0x4B ('K') go to RX_KEY. On 0x45 ('E') set enc_dec=1 and go to RX_DATA. On 0x44 ('D') set enc_dec=0 and go to RX_DATA. On any other byte, pulse err and stay in IDLE.
  - RX_KEY: in_ready=1. Shift KB bytes in, with the counter running 0..KB-1. On the last byte go to LOAD_KEY. key_ok is cleared on entry.
  - LOAD_KEY: in_ready=0. Hold newKey=1 until the cycle in which ldKey=1, then drop newKey the next cycle and go to WAIT_KEY.
  - WAIT_KEY: on doneKey=1, set key_ok=1 and go to IDLE.
  - RX_DATA: in_ready=1. Shift DB bytes in. On the last byte, go to LOAD_DATA if key_ok=1. Otherwise pulse err and go to IDLE, discarding the block.
  - LOAD_DATA: hold newData=1 until ldData=1, then drop it and go to WAIT_DATA.
  - WAIT_DATA: on doneData=1, latch cipher into the tx shift register and assert readData for exactly one cycle. Go to TX.
  - TX: out_valid=1 and out_byte = MSB byte of the tx register. On each accepted byte, shift left by 8. After DB bytes go to IDLE. Backpressure (out_ready=0) holds out_byte stable.
- newKey and newData are never high simultaneously. Both are 0 outside LOAD_*.
- Same-cycle events:
  - If ldKey and doneKey arrive in the same cycle, treat it as ldKey followed by immediate doneKey: go directly to IDLE with key_ok=1.
  - Likewise, if ldData and doneData arrive together, go directly to the readData cycle.
- Core responses outside the matching wait state (for example a stray doneData in IDLE) are ignored.
- plain, key and enc_dec are held stable from the end of RX_* until the state returns to IDLE.
- err is a one-cycle pulse and takes no state of its own. key_ok persists across data operations until the next 'K' command or reset.
- No timeout: a core that never responds leaves the block in LOAD_* or WAIT_*, with busy=1, until R.

Test Plan:
- Key load: send 0x4B followed by bytes 0x00..0x11. Required: key = 0x000102..11, newKey held until the core model pulses ldKey 3 cycles later, and key_ok=1 one cycle after doneKey.
- Encrypt: after the key load, send 0x45 followed by the 12 vector plaintext bytes. Required: enc_dec=1, plain equals the assembled block, newData drops after ldData, and readData is high for exactly 1 cycle on doneData. The 12 output bytes must equal the SIMON 96/144 published test-vector ciphertext, MSB first.
- Decrypt: send 0x44 followed by the ciphertext bytes. Required: enc_dec=0 and the returned bytes equal the original plaintext.
- Data without key: from reset, send 0x45 followed by 12 bytes. Required: err pulses once after the 12th byte, newData never rises, and the state returns to IDLE with key_ok=0.
- Bad command and backpressure: send 0x7A. Required: an err pulse and in_ready staying 1. Then, during TX, hold out_ready=0 for 5 cycles. Required: out_byte stays stable and no byte is lost or duplicated.
- Reset mid-operation: assert R during WAIT_DATA. Required: next cycle all outputs are 0, state is IDLE and key_ok=0. A subsequent 'K' sequence completes normally.
